// File: rtl/sniffer_pkg.sv
// Shared types and constants for the sniffer datapath blocks
// (comparator and match capture buffer).
package sniffer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        DISCARD = 2'd2
    } capture_state_t;

    localparam int WORD_WIDTH = 32;
    localparam int MAC_WIDTH  = 48;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port store: one synchronous write port and one synchronous,
// enabled read port. The storage array itself is never reset.
module capture_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds its value when no read is issued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/match_capture_buffer.sv
// Speculative frame capture buffer: stores each frame, commits it on a match,
// rolls it back otherwise. Optional counters under CAPTURE_DROP_COUNT_EN.
module match_capture_buffer
    import sniffer_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_WIDTH,
    parameter int DEPTH      = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  match,
    input  logic                  frame_end,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  frame_committed,
    output logic                  frame_dropped,
`ifdef CAPTURE_DROP_COUNT_EN
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic [CNT_WIDTH-1:0]  rollback_count,
`endif
    output logic [CNT_WIDTH-1:0]  frame_count,
    output capture_state_t        state_o
);

    localparam int PTR_W = $clog2(DEPTH);

    capture_state_t       state_q;
    logic [PTR_W-1:0]     wr_ptr_q, commit_ptr_q, rd_ptr_q;
    logic                 frame_match_q;
    logic                 rd_valid_q, committed_q, dropped_q;
    logic [CNT_WIDTH-1:0] frame_count_q;

    logic                 accepting, in_frame, frame_match_now;
    logic                 do_read, do_write, overflow, close_frame;
    logic                 commit, rollback, drop;
    logic [PTR_W-1:0]     wr_ptr_after;

    assign empty = (rd_ptr_q == commit_ptr_q);
    assign full  = ((wr_ptr_q + PTR_W'(1)) == rd_ptr_q);

    // A frame starts on its first valid word; a frame_end in IDLE with a word
    // is a one-word frame, so the previous idle cycle's match must not leak in.
    assign accepting       = (state_q != DISCARD);
    assign in_frame        = (state_q == FILL) || data_valid;
    assign frame_match_now = (state_q == FILL) ? (frame_match_q | match) : match;

    assign do_read      = rd_en && !empty;
    assign overflow     = accepting && data_valid && full;
    assign do_write     = accepting && data_valid && !full;
    assign wr_ptr_after = do_write ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    assign close_frame  = accepting && frame_end && in_frame && !overflow;
    assign commit       = close_frame && frame_match_now;
    assign rollback     = close_frame && !frame_match_now;
    assign drop         = ((state_q == DISCARD) && frame_end && (frame_match_q | match)) ||
                          (overflow && frame_end && frame_match_now);

    capture_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (do_write),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .re_i    (do_read),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            commit_ptr_q  <= '0;
            rd_ptr_q      <= '0;
            frame_match_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            committed_q   <= 1'b0;
            dropped_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            rd_valid_q  <= do_read;
            committed_q <= commit;
            dropped_q   <= drop;
            if (do_read) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (commit) begin
                commit_ptr_q <= wr_ptr_after;
                if (frame_count_q != '1) begin
                    frame_count_q <= frame_count_q + CNT_WIDTH'(1);
                end
            end
            case (state_q)
                IDLE, FILL: begin
                    if (overflow) begin
                        wr_ptr_q      <= commit_ptr_q;
                        state_q       <= frame_end ? IDLE : DISCARD;
                        frame_match_q <= frame_end ? 1'b0 : frame_match_now;
                    end else if (close_frame) begin
                        wr_ptr_q      <= commit ? wr_ptr_after : commit_ptr_q;
                        state_q       <= IDLE;
                        frame_match_q <= 1'b0;
                    end else begin
                        wr_ptr_q      <= wr_ptr_after;
                        state_q       <= in_frame ? FILL : IDLE;
                        frame_match_q <= frame_match_now;
                    end
                end
                DISCARD: begin
                    if (frame_end) begin
                        state_q       <= IDLE;
                        frame_match_q <= 1'b0;
                    end else begin
                        frame_match_q <= frame_match_q | match;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CAPTURE_DROP_COUNT_EN
    logic [CNT_WIDTH-1:0] drop_count_q, rollback_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count_q     <= '0;
            rollback_count_q <= '0;
        end else begin
            if (drop && (drop_count_q != '1)) begin
                drop_count_q <= drop_count_q + CNT_WIDTH'(1);
            end
            if (rollback && (rollback_count_q != '1)) begin
                rollback_count_q <= rollback_count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign drop_count     = drop_count_q;
    assign rollback_count = rollback_count_q;
`endif

    assign rd_valid        = rd_valid_q;
    assign frame_committed = committed_q;
    assign frame_dropped   = dropped_q;
    assign frame_count     = frame_count_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_match_capture_buffer.sv
// Directed bench for match_capture_buffer (DEPTH=4) with a queue-based frame
// model checked every cycle; counter ports checked when CAPTURE_DROP_COUNT_EN is set.
module tb_match_capture_buffer;
  import sniffer_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          data_valid, match, frame_end, rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid, empty, full, frame_committed, frame_dropped;
  logic [CW-1:0] frame_count;
  capture_state_t state_dbg;
`ifdef CAPTURE_DROP_COUNT_EN
  logic [CW-1:0] drop_count, rollback_count;
`endif

  match_capture_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .match           (match),
    .frame_end       (frame_end),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .empty           (empty),
    .full            (full),
    .frame_committed (frame_committed),
    .frame_dropped   (frame_dropped),
`ifdef CAPTURE_DROP_COUNT_EN
    .drop_count      (drop_count),
    .rollback_count  (rollback_count),
`endif
    .frame_count     (frame_count),
    .state_o         (state_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: committed-unread words and the open frame's words.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] spec_q[$];
  bit            m_in_frame, m_discard, m_match, model_live;
  logic [DW-1:0] m_rd_data;
  bit            m_rd_valid, m_committed, m_dropped;
  logic [CW-1:0] m_count, m_drops, m_rollbacks;

  always @(posedge clk) begin
    model_live = 1'b1;
    if (rst) begin
      exp_q.delete(); spec_q.delete();
      m_in_frame = 0; m_discard = 0; m_match = 0;
      m_rd_data = '0; m_rd_valid = 0; m_committed = 0; m_dropped = 0;
      m_count = '0; m_drops = '0; m_rollbacks = '0;
    end else begin
      bit was_empty, was_full, fm;
      was_empty = (exp_q.size() == 0);
      was_full  = ((exp_q.size() + spec_q.size()) == DEPTH - 1);
      m_rd_valid = 0; m_committed = 0; m_dropped = 0;
      if (rd_en && !was_empty) begin
        m_rd_data  = exp_q.pop_front();
        m_rd_valid = 1;
      end
      if (m_discard) begin
        m_match = m_match | match;
        if (frame_end) begin
          if (m_match) begin m_dropped = 1; if (m_drops != '1) m_drops++; end
          m_discard = 0; m_match = 0;
        end
      end else begin
        fm = m_in_frame ? (m_match | match) : match;
        if (data_valid && was_full) begin
          spec_q.delete();
          m_in_frame = 0;
          if (frame_end) begin
            if (fm) begin m_dropped = 1; if (m_drops != '1) m_drops++; end
            m_match = 0;
          end else begin
            m_discard = 1; m_match = fm;
          end
        end else begin
          if (data_valid) spec_q.push_back(data_in);
          if (frame_end && (m_in_frame || data_valid)) begin
            if (fm) begin
              foreach (spec_q[i]) exp_q.push_back(spec_q[i]);
              m_committed = 1;
              if (m_count != '1) m_count++;
            end else if (m_rollbacks != '1) begin
              m_rollbacks++;
            end
            spec_q.delete(); m_in_frame = 0; m_match = 0;
          end else if (m_in_frame || data_valid) begin
            m_in_frame = 1; m_match = fm;
          end else begin
            m_match = match;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("empty",     64'(empty),           64'(exp_q.size() == 0));
      chk("full",      64'(full),            64'((exp_q.size() + spec_q.size()) == DEPTH - 1));
      chk("rd_valid",  64'(rd_valid),        64'(m_rd_valid));
      chk("rd_data",   64'(rd_data),         64'(m_rd_data));
      chk("committed", 64'(frame_committed), 64'(m_committed));
      chk("dropped",   64'(frame_dropped),   64'(m_dropped));
      chk("count",     64'(frame_count),     64'(m_count));
`ifdef CAPTURE_DROP_COUNT_EN
      chk("drop_count",     64'(drop_count),     64'(m_drops));
      chk("rollback_count", 64'(rollback_count), 64'(m_rollbacks));
`endif
    end
  end

  task automatic cyc(input logic dv, input logic [DW-1:0] d, input logic m,
                     input logic fe, input logic re);
    data_valid = dv; data_in = d; match = m; frame_end = fe; rd_en = re;
    @(posedge clk); #1;
    data_valid = 0; match = 0; frame_end = 0; rd_en = 0;
  endtask

  task automatic read_word(input string name, input logic [DW-1:0] exp);
    cyc(0, '0, 0, 0, 1);
    chk(name, 64'(rd_data), 64'(exp));
    chk({name, "_valid"}, 64'(rd_valid), 64'(1));
  endtask

  task automatic run_unmatched();
    cyc(1, 32'h01B2C3D4, 0, 0, 0);
    cyc(1, 32'hE5F60000, 0, 0, 0);
    cyc(1, 32'h00000000, 0, 1, 0);
    chk("t2_no_commit", 64'(frame_committed), 64'(0));
    chk("t2_empty",     64'(empty),           64'(1));
    cyc(0, '0, 0, 0, 0);
    chk("t2_not_full",  64'(full),            64'(0));
  endtask

  task automatic run_overflow();
    for (int i = 0; i < 5; i++) begin
      cyc(1, 32'hFFFFFFFF, 1, (i == 4), 0);
      if (i == 2) chk("t3_full_after3", 64'(full), 64'(1));
      if (i == 3) chk("t3_discard", 64'(state_dbg), 64'(DISCARD));
    end
    chk("t3_dropped", 64'(frame_dropped), 64'(1));
    chk("t3_empty",   64'(empty),         64'(1));
    cyc(1, 32'hA5A50001, 1, 0, 0);
    cyc(1, 32'hA5A50002, 1, 1, 0);
    chk("t3_commit", 64'(frame_committed), 64'(1));
    read_word("t3_rd0", 32'hA5A50001);
    read_word("t3_rd1", 32'hA5A50002);
    chk("t3_empty_after", 64'(empty), 64'(1));
  endtask

  initial begin
    rst = 1; data_in = '0; data_valid = 0; match = 0; frame_end = 0; rd_en = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 64'(empty),       64'(1));
    chk("rst_full",  64'(full),        64'(0));
    chk("rst_valid", 64'(rd_valid),    64'(0));
    chk("rst_data",  64'(rd_data),     64'(0));
    chk("rst_count", 64'(frame_count), 64'(0));
    rst = 0;
    cyc(0, '0, 0, 0, 0);

    // Flagged frame: match from word 2, frame_end on word 3.
    cyc(1, 32'h01B2C3D4, 0, 0, 0);
    cyc(1, 32'hE5F60000, 1, 0, 0);
    cyc(1, 32'h00000000, 1, 1, 0);
    chk("t1_commit", 64'(frame_committed), 64'(1));
    chk("t1_count",  64'(frame_count),     64'(1));
    chk("t1_empty",  64'(empty),           64'(0));
    read_word("t1_rd0", 32'h01B2C3D4);
    read_word("t1_rd1", 32'hE5F60000);
    read_word("t1_rd2", 32'h00000000);
    chk("t1_empty_after", 64'(empty), 64'(1));
    cyc(0, '0, 0, 0, 1);
    chk("t1_empty_read", 64'(rd_valid), 64'(0));

    run_unmatched();
    chk("t2_count", 64'(frame_count), 64'(1));

    run_overflow();
    chk("t3_count", 64'(frame_count), 64'(2));

    // Frame A committed, then read while frame B commits.
    cyc(1, 32'h00000100, 1, 0, 0);
    cyc(1, 32'h00000101, 1, 1, 0);
    cyc(1, 32'h00000200, 1, 0, 1);
    chk("t4_rdA0", 64'(rd_data), 64'(32'h100));
    cyc(1, 32'h00000201, 1, 1, 1);
    chk("t4_rdA1",   64'(rd_data),         64'(32'h101));
    chk("t4_commitB", 64'(frame_committed), 64'(1));
    read_word("t4_rdB0", 32'h00000200);
    read_word("t4_rdB1", 32'h00000201);
    chk("t4_count", 64'(frame_count), 64'(4));
    chk("t4_empty", 64'(empty),       64'(1));

    // Reset in the middle of a matched frame, then a one-word frame.
    cyc(1, 32'h00000011, 1, 0, 0);
    cyc(1, 32'h00000022, 1, 0, 0);
    rst = 1;
    cyc(0, '0, 0, 0, 0);
    rst = 0;
    chk("t5_empty", 64'(empty),       64'(1));
    chk("t5_count", 64'(frame_count), 64'(0));
    chk("t5_valid", 64'(rd_valid),    64'(0));
    cyc(1, 32'h00000033, 1, 1, 0);
    chk("t5_commit", 64'(frame_committed), 64'(1));
    chk("t5_count1", 64'(frame_count),     64'(1));
    read_word("t5_rd", 32'h00000033);

    run_overflow();
    run_overflow();
    run_unmatched();
    chk("t6_count", 64'(frame_count), 64'(3));
`ifdef CAPTURE_DROP_COUNT_EN
    chk("t6_drop_count",     64'(drop_count),     64'(2));
    chk("t6_rollback_count", 64'(rollback_count), 64'(1));
`endif
    repeat (2) cyc(0, '0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
